// File: rtl/dmi_target_if.sv
`default_nettype none
// dmi_target_if: DMI request/response handshake bundle between the DTM and the debug module.
// Revision 1.0
interface dmi_target_if;
  logic [40:0] dmi_req_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic [33:0] dmi_resp_o;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;

  modport master (
    output dmi_req_i,
    output dmi_req_valid_i,
    output dmi_resp_ready_i,
    input  dmi_req_ready_o,
    input  dmi_resp_o,
    input  dmi_resp_valid_o
  );

  modport slave (
    input  dmi_req_i,
    input  dmi_req_valid_i,
    input  dmi_resp_ready_i,
    output dmi_req_ready_o,
    output dmi_resp_o,
    output dmi_resp_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/dmi_target.sv
`default_nettype none
// dmi_target: DMI responder with data0/1, dmcontrol, dmstatus, abstractcs, command and a busy window.
// Revision 1.0
module dmi_target #(
  parameter int unsigned CmdLatency = 8,
  parameter logic [3:0]  DmVersion  = 4'h2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dmi_target_if.slave  dmi,
  input  logic         unlock_i,
  output logic         haltreq_o,
  output logic         ndmreset_o,
  output logic [31:0]  cmd_o,
  output logic         cmd_start_o
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DATA1      = 7'h05;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] RC_OK   = 2'd0;
  localparam logic [1:0] RC_FAIL = 2'd2;
  localparam logic [1:0] RC_BUSY = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [7:0] LATENCY = 8'(CmdLatency);

  logic [0:0]  state_q, state_d;
  logic        accept;
  logic        req_ready, resp_valid;

  logic [6:0]  addr;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic        is_write, is_read, gated;

  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] cmd_q, cmd_d;
  logic        haltreq_q, haltreq_d;
  logic        ndmreset_q, ndmreset_d;
  logic        dmactive_q, dmactive_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic        busy;
  logic        cmd_start_q, cmd_start_d;
  logic [33:0] resp_q, resp_d;
  logic [31:0] rdata;
  logic [1:0]  rcode;

  assign addr     = dmi.dmi_req_i[40:34];
  assign op       = dmi.dmi_req_i[33:32];
  assign wdata    = dmi.dmi_req_i[31:0];
  assign is_write = (op == OP_WRITE);
  assign is_read  = (op == OP_READ);
  assign gated    = (addr == ADDR_DATA0) || (addr == ADDR_DATA1) || (addr == ADDR_COMMAND);
  assign busy     = (busy_cnt_q != 8'd0);
  assign accept   = (state_q == ST_IDLE) && dmi.dmi_req_valid_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dmi.dmi_req_valid_i)  state_d = ST_RESP;
      ST_RESP: if (dmi.dmi_resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request decode: side effects and response word for the request being accepted.
  always_comb begin
    data0_d     = data0_q;
    data1_d     = data1_q;
    cmd_d       = cmd_q;
    haltreq_d   = haltreq_q;
    ndmreset_d  = ndmreset_q;
    dmactive_d  = dmactive_q;
    cmderr_d    = cmderr_q;
    busy_cnt_d  = busy ? (busy_cnt_q - 8'd1) : busy_cnt_q;
    cmd_start_d = 1'b0;
    rdata       = 32'h0;
    rcode       = RC_OK;

    if (accept) begin
      if (op == OP_NOP) begin
        rcode = RC_OK;
      end else if (op == OP_RSVD) begin
        rcode = RC_FAIL;
      end else if (is_write && !unlock_i) begin
        // Locked writes have no side effect at all, not even a busy error.
        rcode = RC_FAIL;
      end else if (busy && gated) begin
        rcode = RC_BUSY;
        if (cmderr_q == 3'd0) cmderr_d = 3'd1;
      end else if (is_write) begin
        case (addr)
          ADDR_DATA0: data0_d = wdata;
          ADDR_DATA1: data1_d = wdata;
          ADDR_DMCONTROL: begin
            haltreq_d  = wdata[31];
            ndmreset_d = wdata[1];
            dmactive_d = wdata[0];
            if (!wdata[0]) begin
              data0_d     = 32'h0;
              data1_d     = 32'h0;
              cmderr_d    = 3'd0;
              haltreq_d   = 1'b0;
              ndmreset_d  = 1'b0;
              busy_cnt_d  = 8'd0;
              cmd_start_d = 1'b0;
            end
          end
          ADDR_ABSTRACTCS: cmderr_d = cmderr_q & ~wdata[10:8];
          ADDR_COMMAND: begin
            if (cmderr_q == 3'd0) begin
              cmd_d       = wdata;
              cmd_start_d = 1'b1;
              busy_cnt_d  = LATENCY;
            end
          end
          default: rcode = RC_OK;
        endcase
      end else if (is_read) begin
        case (addr)
          ADDR_DATA0:      rdata = data0_q;
          ADDR_DATA1:      rdata = data1_q;
          ADDR_DMCONTROL:  rdata = {haltreq_q, 29'h0, ndmreset_q, dmactive_q} & 32'h8000_0003;
          ADDR_DMSTATUS:   rdata = {24'h0, unlock_i, 3'b000, DmVersion};
          ADDR_ABSTRACTCS: rdata = {19'h0, busy, 1'b0, cmderr_q, 4'h0, 4'd2};
          default:         rdata = 32'h0;
        endcase
      end
    end
    resp_d = {rdata, rcode};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q     <= 32'h0;
      data1_q     <= 32'h0;
      cmd_q       <= 32'h0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      dmactive_q  <= 1'b0;
      cmderr_q    <= 3'd0;
      busy_cnt_q  <= 8'd0;
      cmd_start_q <= 1'b0;
      resp_q      <= 34'h0;
    end else begin
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      cmd_q       <= cmd_d;
      haltreq_q   <= haltreq_d;
      ndmreset_q  <= ndmreset_d;
      dmactive_q  <= dmactive_d;
      cmderr_q    <= cmderr_d;
      busy_cnt_q  <= busy_cnt_d;
      cmd_start_q <= cmd_start_d;
      if (accept) resp_q <= resp_d;
    end
  end

  assign dmi.dmi_req_ready_o  = req_ready;
  assign dmi.dmi_resp_valid_o = resp_valid;
  assign dmi.dmi_resp_o       = resp_q;
  assign haltreq_o            = haltreq_q;
  assign ndmreset_o           = ndmreset_q;
  assign cmd_o                = cmd_q;
  assign cmd_start_o          = cmd_start_q;

endmodule
`default_nettype wire

// File: tb/tb_dmi_target.sv
`default_nettype none
// tb_dmi_target: table vectors, directed multi-cycle sequences and a randomized run against a model.
// Revision 1.0
module tb_dmi_target;
  localparam int CMD_LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        unlock;
  logic        haltreq, ndmreset, cmd_start;
  logic [31:0] cmd;
  longint      edge_cnt = 0;
  int          checks = 0;
  int          fails = 0;

  dmi_target_if dmi ();

  dmi_target #(.CmdLatency(CMD_LAT), .DmVersion(4'h2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dmi         (dmi),
    .unlock_i    (unlock),
    .haltreq_o   (haltreq),
    .ndmreset_o  (ndmreset),
    .cmd_o       (cmd),
    .cmd_start_o (cmd_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request with resp_ready held high; starts and ends just after a negedge.
  task automatic xfer(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd, input logic unl,
                      output logic [33:0] resp, output logic st, output longint e);
    int n;
    unlock = unl;
    dmi.dmi_req_i = {a, op, wd};
    dmi.dmi_req_valid_i = 1'b1;
    n = 0;
    while (dmi.dmi_req_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    dmi.dmi_req_valid_i = 1'b0;
    n = 0;
    while (dmi.dmi_resp_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("resp_valid_after_accept", 64'(dmi.dmi_resp_valid_o), 64'd1);
    resp = dmi.dmi_resp_o;
    st   = cmd_start;
    e    = edge_cnt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dmi.dmi_req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: busy is a time window measured in accept edges.
  logic [31:0] m_data0, m_data1, m_cmd;
  logic        m_halt, m_ndm, m_act;
  logic [2:0]  m_cmderr;
  longint      m_busy_end;

  function automatic void model_reset();
    m_data0 = 0; m_data1 = 0; m_cmd = 0; m_halt = 0; m_ndm = 0; m_act = 0;
    m_cmderr = 0; m_busy_end = 0;
  endfunction

  function automatic void model(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd,
                                input logic unl, input longint e, output logic [33:0] r, output logic st);
    logic [31:0] rd;
    logic [1:0]  rc;
    bit          bsy, hit;
    rd = 0; rc = 0; st = 0;
    bsy = (e <= m_busy_end);
    hit = (a == 7'h04) || (a == 7'h05) || (a == 7'h17);
    if (op == 2'd0) rc = 0;
    else if (op == 2'd3) rc = 2;
    else if (op == 2'd2 && !unl) rc = 2;
    else if (bsy && hit) begin
      rc = 3;
      if (m_cmderr == 0) m_cmderr = 1;
    end else if (op == 2'd2) begin
      if (a == 7'h04) m_data0 = wd;
      else if (a == 7'h05) m_data1 = wd;
      else if (a == 7'h10) begin
        if (wd[0]) begin m_halt = wd[31]; m_ndm = wd[1]; m_act = 1; end
        else begin
          m_halt = 0; m_ndm = 0; m_act = 0; m_data0 = 0; m_data1 = 0; m_cmderr = 0; m_busy_end = 0;
        end
      end else if (a == 7'h16) m_cmderr = m_cmderr & ~wd[10:8];
      else if (a == 7'h17 && m_cmderr == 0) begin
        m_cmd = wd; st = 1; m_busy_end = e + CMD_LAT;
      end
    end else begin
      if (a == 7'h04) rd = m_data0;
      else if (a == 7'h05) rd = m_data1;
      else if (a == 7'h10) rd = (m_halt ? 32'h8000_0000 : 0) + (m_ndm ? 2 : 0) + (m_act ? 1 : 0);
      else if (a == 7'h11) rd = 32'h2 + (unl ? 32'h80 : 0);
      else if (a == 7'h16) rd = 32'h2 + (32'(m_cmderr) * 256) + (bsy ? 32'h1000 : 0);
    end
    r = {rd, rc};
  endfunction

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        unl;
    logic [33:0] exp_resp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [33:0] resp, exp_r;
    logic        st, exp_st;
    longint      e;

    vecs[0]  = '{7'h11, 2'd1, 32'h0,         1'b1, {32'h0000_0082, 2'd0}};
    vecs[1]  = '{7'h16, 2'd1, 32'h0,         1'b1, {32'h0000_0002, 2'd0}};
    vecs[2]  = '{7'h04, 2'd2, 32'hDEAD_BEEF, 1'b0, {32'h0,         2'd2}};
    vecs[3]  = '{7'h04, 2'd1, 32'h0,         1'b0, {32'h0,         2'd0}};
    vecs[4]  = '{7'h04, 2'd2, 32'hDEAD_BEEF, 1'b1, {32'h0,         2'd0}};
    vecs[5]  = '{7'h04, 2'd1, 32'h0,         1'b1, {32'hDEAD_BEEF, 2'd0}};
    vecs[6]  = '{7'h04, 2'd3, 32'hFFFF_FFFF, 1'b1, {32'h0,         2'd2}};
    vecs[7]  = '{7'h04, 2'd0, 32'h1234_5678, 1'b1, {32'h0,         2'd0}};
    vecs[8]  = '{7'h04, 2'd1, 32'h0,         1'b1, {32'hDEAD_BEEF, 2'd0}};
    vecs[9]  = '{7'h10, 2'd2, 32'h8000_0003, 1'b1, {32'h0,         2'd0}};
    vecs[10] = '{7'h10, 2'd1, 32'h0,         1'b1, {32'h8000_0003, 2'd0}};
    vecs[11] = '{7'h11, 2'd2, 32'hFFFF_FFFF, 1'b1, {32'h0,         2'd0}};
    vecs[12] = '{7'h11, 2'd2, 32'h0,         1'b0, {32'h0,         2'd2}};
    vecs[13] = '{7'h11, 2'd1, 32'h0,         1'b0, {32'h0000_0002, 2'd0}};
    vecs[14] = '{7'h10, 2'd2, 32'h0,         1'b0, {32'h0,         2'd2}};
    vecs[15] = '{7'h10, 2'd1, 32'h0,         1'b1, {32'h8000_0003, 2'd0}};
    vecs[16] = '{7'h30, 2'd2, 32'h1,         1'b1, {32'h0,         2'd0}};
    vecs[17] = '{7'h30, 2'd1, 32'h0,         1'b1, {32'h0,         2'd0}};
    vecs[18] = '{7'h17, 2'd1, 32'h0,         1'b1, {32'h0,         2'd0}};

    unlock = 1'b1;
    dmi.dmi_req_i = '0;
    dmi.dmi_req_valid_i = 1'b0;
    dmi.dmi_resp_ready_i = 1'b1;
    do_reset();

    chk("rst_req_ready",  64'(dmi.dmi_req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(dmi.dmi_resp_valid_o), 64'd0);
    chk("rst_resp",       64'(dmi.dmi_resp_o), 64'd0);
    chk("rst_haltreq",    64'(haltreq), 64'd0);
    chk("rst_ndmreset",   64'(ndmreset), 64'd0);
    chk("rst_cmd",        64'(cmd), 64'd0);
    chk("rst_cmd_start",  64'(cmd_start), 64'd0);

    for (int i = 0; i < 19; i++) begin
      xfer(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].unl, resp, st, e);
      chk($sformatf("vec%0d_resp", i), 64'(resp), 64'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_start", i), 64'(st), 64'd0);
    end
    chk("dmctl_haltreq",  64'(haltreq), 64'd1);
    chk("dmctl_ndmreset", 64'(ndmreset), 64'd1);

    // dmactive=0 clears control bits and data registers
    xfer(7'h10, 2'd2, 32'h0, 1'b1, resp, st, e);
    chk("dmclr_resp", 64'(resp), 64'd0);
    chk("dmclr_haltreq", 64'(haltreq), 64'd0);
    chk("dmclr_ndmreset", 64'(ndmreset), 64'd0);
    xfer(7'h04, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("dmclr_data0", 64'(resp), 64'd0);

    // Command start, busy window, busy error and cmderr clearing
    xfer(7'h17, 2'd2, 32'h0022_1000, 1'b1, resp, st, e);
    chk("cmd_resp", 64'(resp), 64'd0);
    chk("cmd_start_pulse", 64'(st), 64'd1);
    chk("cmd_value", 64'(cmd), 64'h0022_1000);
    chk("cmd_start_one_cycle", 64'(cmd_start), 64'd0);
    xfer(7'h16, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("acs_busy", 64'(resp), 64'({32'h0000_1002, 2'd0}));
    xfer(7'h05, 2'd2, 32'h1234_5678, 1'b1, resp, st, e);
    chk("busy_write_data1", 64'(resp), 64'({32'h0, 2'd3}));
    xfer(7'h16, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("acs_busy_cmderr", 64'(resp), 64'({32'h0000_1102, 2'd0}));
    repeat (10) @(negedge clk);
    xfer(7'h16, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("acs_idle_cmderr", 64'(resp), 64'({32'h0000_0102, 2'd0}));
    xfer(7'h05, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("data1_unchanged", 64'(resp), 64'd0);
    xfer(7'h17, 2'd2, 32'h0000_ABCD, 1'b1, resp, st, e);
    chk("cmd_blocked_resp", 64'(resp), 64'd0);
    chk("cmd_blocked_start", 64'(st), 64'd0);
    chk("cmd_blocked_value", 64'(cmd), 64'h0022_1000);
    xfer(7'h16, 2'd2, 32'h0000_0700, 1'b1, resp, st, e);
    chk("cmderr_w1c_resp", 64'(resp), 64'd0);
    xfer(7'h16, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("cmderr_cleared", 64'(resp), 64'({32'h0000_0002, 2'd0}));

    // Busy boundary: reads at N+2..N+10; the read at N+CmdLatency still sees busy
    xfer(7'h17, 2'd2, 32'h0000_0055, 1'b1, resp, st, e);
    chk("cmd2_start", 64'(st), 64'd1);
    for (int k = 0; k < 5; k++) begin
      xfer(7'h16, 2'd1, 32'h0, 1'b1, resp, st, e);
      chk($sformatf("busy_edge_%0d", k), 64'(resp),
          64'({(k < 4) ? 32'h0000_1002 : 32'h0000_0002, 2'd0}));
    end

    // dmactive=0 during busy cancels the window and keeps cmd_o
    xfer(7'h17, 2'd2, 32'h0000_0077, 1'b1, resp, st, e);
    chk("cmd3_start", 64'(st), 64'd1);
    xfer(7'h10, 2'd2, 32'h0, 1'b1, resp, st, e);
    chk("cmd3_dmclr_resp", 64'(resp), 64'd0);
    xfer(7'h16, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("cmd3_not_busy", 64'(resp), 64'({32'h0000_0002, 2'd0}));
    chk("cmd3_cmd_kept", 64'(cmd), 64'h0000_0077);

    // Response held while resp_ready is low
    xfer(7'h04, 2'd2, 32'hCAFE_F00D, 1'b1, resp, st, e);
    dmi.dmi_resp_ready_i = 1'b0;
    dmi.dmi_req_i = {7'h04, 2'd1, 32'h0};
    dmi.dmi_req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmi.dmi_req_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_resp", 64'(dmi.dmi_resp_o), 64'({32'hCAFE_F00D, 2'd0}));
      chk("hold_valid", 64'(dmi.dmi_resp_valid_o), 64'd1);
      chk("hold_req_ready", 64'(dmi.dmi_req_ready_o), 64'd0);
      @(negedge clk);
    end
    dmi.dmi_resp_ready_i = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", 64'(dmi.dmi_req_ready_o), 64'd1);
    chk("hold_release_valid", 64'(dmi.dmi_resp_valid_o), 64'd0);

    // Reset while a response is pending
    xfer(7'h10, 2'd2, 32'h8000_0003, 1'b1, resp, st, e);
    dmi.dmi_resp_ready_i = 1'b0;
    dmi.dmi_req_i = {7'h04, 2'd1, 32'h0};
    dmi.dmi_req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmi.dmi_req_valid_i = 1'b0;
    chk("prerst_valid", 64'(dmi.dmi_resp_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(dmi.dmi_resp_valid_o), 64'd0);
    chk("midrst_ready", 64'(dmi.dmi_req_ready_o), 64'd1);
    chk("midrst_resp", 64'(dmi.dmi_resp_o), 64'd0);
    chk("midrst_haltreq", 64'(haltreq), 64'd0);
    chk("midrst_ndmreset", 64'(ndmreset), 64'd0);
    chk("midrst_cmd", 64'(cmd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmi.dmi_resp_ready_i = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 64'(dmi.dmi_resp_valid_o), 64'd0);
    xfer(7'h04, 2'd1, 32'h0, 1'b1, resp, st, e);
    chk("postrst_data0", 64'(resp), 64'd0);

    // Randomized traffic against the reference model
    model_reset();
    for (int i = 0; i < 160; i++) begin
      logic [6:0]  a;
      logic [1:0]  op;
      logic [31:0] wd;
      logic        unl;
      int          sel, gap;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: a = 7'h04;
        1: a = 7'h05;
        2: a = 7'h10;
        3: a = 7'h11;
        4: a = 7'h16;
        6: a = 7'($urandom_range(0, 127));
        default: a = 7'h17;
      endcase
      sel = int'($urandom_range(0, 9));
      op = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd3 : (sel < 6) ? 2'd1 : 2'd2;
      wd = $urandom;
      if (a == 7'h10 && $urandom_range(0, 4) != 0) wd[0] = 1'b1;
      unl = ($urandom_range(0, 5) != 0);
      gap = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) gap = int'($urandom_range(4, 12));
      repeat (gap) @(negedge clk);
      xfer(a, op, wd, unl, resp, st, e);
      model(a, op, wd, unl, e, exp_r, exp_st);
      chk($sformatf("rnd%0d_resp a=%0h op=%0d", i, a, op), 64'(resp), 64'(exp_r));
      chk($sformatf("rnd%0d_start", i), 64'(st), 64'(exp_st));
      chk($sformatf("rnd%0d_cmd", i), 64'(cmd), 64'(m_cmd));
      chk($sformatf("rnd%0d_haltreq", i), 64'(haltreq), 64'(m_halt));
      chk($sformatf("rnd%0d_ndmreset", i), 64'(ndmreset), 64'(m_ndm));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
